multi_phase_clkgen: RTL and testbench

- Synthesisable, parametrised successor to the behavioural phase-shifted clock stimulus.
- Generates N_CH registered pulse trains that share one programmable high/low time.
- Each channel has its own start delay, used as a phase offset.
- Runs for a programmable number of periods (burst), or continuously until stopped.
- Used as an on-chip stimulus and strobe source in testbenches and datapath demos.

---
 rtl/multi_phase_clkgen.sv | 227 ++++++++++++++++++++++
 tb/tb_multi_phase_clkgen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_phase_clkgen.sv
`default_nettype none
// ============================================================================
// Module   : multi_phase_clkgen
// Purpose  : N_CH registered pulse trains that share one programmable
//            high/low time. Each channel has its own start delay (phase
//            offset). A run lasts burst_len_i periods per channel, or runs
//            continuously when burst_len_i is zero until stop_i or rst.
// Ports    : clk          system clock, rising edge
//            rst          asynchronous active-high reset
//            start_i      one-cycle launch request, sampled only when idle
//            stop_i       synchronous abort of a run in progress
//            high_time_i  high cycles per period (0 treated as 1)
//            low_time_i   low cycles per period (0 treated as 1)
//            phase_i      per-channel start delay, channel k at [k*CNT_W +: CNT_W]
//            burst_len_i  periods per channel, 0 = continuous
//            clk_out_o    generated waveforms (registered)
//            busy_o       a run is in progress (registered)
//            done_o       one-cycle pulse when a finite burst completes
// Revision : 1.0 - initial release
// ============================================================================
module multi_phase_clkgen #(
   parameter int N_CH    = 2,
   parameter int CNT_W   = 8,
   parameter int BURST_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic                  stop_i,
   input  logic [CNT_W-1:0]      high_time_i,
   input  logic [CNT_W-1:0]      low_time_i,
   input  logic [N_CH*CNT_W-1:0] phase_i,
   input  logic [BURST_W-1:0]    burst_len_i,
   output logic [N_CH-1:0]       clk_out_o,
   output logic                  busy_o,
   output logic                  done_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DELAY = 3'd1,
      S_HIGH  = 3'd2,
      S_LOW   = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0]   C_CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]   C_CNT_ZERO  = '0;
   localparam logic [BURST_W-1:0] C_BURST_ONE = BURST_W'(1);

   // -------------------------------------------------------------------------
   // Latched run configuration. The phase value needs no holding register:
   // it is only consumed on the launch edge, where it is loaded straight into
   // each channel's delay counter.
   // -------------------------------------------------------------------------
   logic [CNT_W-1:0]   high_q;
   logic [CNT_W-1:0]   low_q;
   logic [BURST_W-1:0] burst_q;

   logic               busy_q;
   logic               busy_d;
   logic               done_q;
   logic               done_d;
   logic [N_CH-1:0]    clk_out_q;

   logic               w_launch;
   logic               w_abort;
   logic [CNT_W-1:0]   w_high_eff;
   logic [CNT_W-1:0]   w_low_eff;

   logic [N_CH-1:0]    w_fin_q;
   logic [N_CH-1:0]    w_fin_d;
   logic [N_CH-1:0]    w_run_d;
   logic [N_CH-1:0]    w_high_d;
   logic               w_all_fin_q;

   // stop has priority over start; both are qualified by the idle/busy state
   // so start during a run and stop while idle are both no-ops.
   assign w_launch = start_i & ~busy_q & ~stop_i;
   assign w_abort  = stop_i & busy_q;

   assign w_high_eff = (high_time_i == C_CNT_ZERO) ? C_CNT_ONE : high_time_i;
   assign w_low_eff  = (low_time_i  == C_CNT_ZERO) ? C_CNT_ONE : low_time_i;

   assign w_all_fin_q = &w_fin_q;

   // Busy while any channel is active, except in the cycle where all channels
   // sit in FIN together: that cycle is the done cycle.
   assign busy_d = (|w_run_d) & ~(&w_fin_d);
   assign done_d = &w_fin_d;

   // -------------------------------------------------------------------------
   // Per-channel FSM. Counters hold "cycles remaining after this one", so a
   // state that must last N cycles is entered with N-1 and left at zero.
   // -------------------------------------------------------------------------
   genvar k;
   generate
      for (k = 0; k < N_CH; k++) begin : g_ch
         state_t             state_q;
         state_t             state_d;
         logic [CNT_W-1:0]   cnt_q;
         logic [CNT_W-1:0]   cnt_d;
         logic [BURST_W-1:0] per_q;
         logic [BURST_W-1:0] per_d;
         logic [BURST_W-1:0] w_per_inc;
         logic [CNT_W-1:0]   w_ph_in;

         assign w_ph_in   = phase_i[k*CNT_W +: CNT_W];
         assign w_per_inc = per_q + C_BURST_ONE;

         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            per_d   = per_q;
            if (w_abort) begin
               // Partial periods are discarded.
               state_d = S_IDLE;
               cnt_d   = C_CNT_ZERO;
               per_d   = '0;
            end else if (w_launch) begin
               per_d = '0;
               if (w_ph_in == C_CNT_ZERO) begin
                  state_d = S_HIGH;
                  cnt_d   = w_high_eff - C_CNT_ONE;
               end else begin
                  state_d = S_DELAY;
                  cnt_d   = w_ph_in - C_CNT_ONE;
               end
            end else begin
               case (state_q)
                  S_IDLE: begin
                     state_d = S_IDLE;
                  end
                  S_DELAY: begin
                     if (cnt_q == C_CNT_ZERO) begin
                        state_d = S_HIGH;
                        cnt_d   = high_q - C_CNT_ONE;
                     end else begin
                        cnt_d = cnt_q - C_CNT_ONE;
                     end
                  end
                  S_HIGH: begin
                     if (cnt_q == C_CNT_ZERO) begin
                        state_d = S_LOW;
                        cnt_d   = low_q - C_CNT_ONE;
                     end else begin
                        cnt_d = cnt_q - C_CNT_ONE;
                     end
                  end
                  S_LOW: begin
                     if (cnt_q == C_CNT_ZERO) begin
                        // Period counter wraps freely in continuous mode.
                        per_d = w_per_inc;
                        if ((burst_q != '0) && (w_per_inc == burst_q)) begin
                           state_d = S_FIN;
                        end else begin
                           state_d = S_HIGH;
                           cnt_d   = high_q - C_CNT_ONE;
                        end
                     end else begin
                        cnt_d = cnt_q - C_CNT_ONE;
                     end
                  end
                  S_FIN: begin
                     // Wait for the slowest channel; the cycle where all are
                     // in FIN is the done cycle, after which everyone idles.
                     if (w_all_fin_q) begin
                        state_d = S_IDLE;
                     end
                  end
                  default: begin
                     state_d = S_IDLE;
                  end
               endcase
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state_q <= S_IDLE;
               cnt_q   <= C_CNT_ZERO;
               per_q   <= '0;
            end else begin
               state_q <= state_d;
               cnt_q   <= cnt_d;
               per_q   <= per_d;
            end
         end

         assign w_fin_q[k]  = (state_q == S_FIN);
         assign w_fin_d[k]  = (state_d == S_FIN);
         assign w_run_d[k]  = (state_d != S_IDLE);
         // Outputs are registered from the next state so the waveform lines
         // up with the state it belongs to, with no input-to-output path.
         assign w_high_d[k] = (state_d == S_HIGH);
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Configuration latch and registered outputs.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         high_q    <= C_CNT_ZERO;
         low_q     <= C_CNT_ZERO;
         burst_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         clk_out_q <= '0;
      end else begin
         if (w_launch) begin
            high_q  <= w_high_eff;
            low_q   <= w_low_eff;
            burst_q <= burst_len_i;
         end
         busy_q    <= busy_d;
         done_q    <= done_d;
         clk_out_q <= w_high_d;
      end
   end

   assign clk_out_o = clk_out_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_phase_clkgen.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_phase_clkgen
// Purpose  : Scoreboard bench for multi_phase_clkgen. A reference model
//            computes each cycle's expected {clk_out, busy, done} from the
//            latched run parameters with plain arithmetic and queues it; a
//            monitor pops and compares on every falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_phase_clkgen;

   localparam int N_CH    = 2;
   localparam int CNT_W   = 8;
   localparam int BURST_W = 8;
   localparam int EW      = N_CH + 2;

   logic                  clk;
   logic                  rst;
   logic                  start;
   logic                  stop;
   logic [CNT_W-1:0]      high_time;
   logic [CNT_W-1:0]      low_time;
   logic [N_CH*CNT_W-1:0] phase;
   logic [BURST_W-1:0]    burst_len;
   logic [N_CH-1:0]       clk_out;
   logic                  busy;
   logic                  done;

   int n_vec = 0;
   int n_err = 0;

   multi_phase_clkgen #(
      .N_CH    (N_CH),
      .CNT_W   (CNT_W),
      .BURST_W (BURST_W)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start),
      .stop_i      (stop),
      .high_time_i (high_time),
      .low_time_i  (low_time),
      .phase_i     (phase),
      .burst_len_i (burst_len),
      .clk_out_o   (clk_out),
      .busy_o      (busy),
      .done_o      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------------
   // Reference model: a run is described by its launch edge and parameters;
   // channel k is high when (c - t0 - 1 - ph_k) lies in the first H cycles of
   // a period and within burst_len periods; done lands one cycle after the
   // slowest channel finishes.
   // ------------------------------------------------------------------------
   logic [EW-1:0] exp_q[$];
   bit  primed = 0;
   bit  run_on = 0;
   bit  m_busy = 0;
   int  m_h, m_l, m_bl, m_t0;
   int  m_ph[N_CH];
   int  m_edge = 0;
   int  n_rel, rel, per, maxph;
   logic [N_CH-1:0] ck;
   logic [EW-1:0]   ev;

   always @(posedge clk) begin
      ev = '0;
      if (rst) begin
         run_on = 0;
      end else begin
         if (stop && m_busy) begin
            run_on = 0;
         end else if (start && !stop && !m_busy) begin
            m_h  = (high_time == 0) ? 1 : int'(high_time);
            m_l  = (low_time  == 0) ? 1 : int'(low_time);
            m_bl = int'(burst_len);
            for (int i = 0; i < N_CH; i++) m_ph[i] = int'(phase[i*CNT_W +: CNT_W]);
            m_t0   = m_edge;
            run_on = 1;
         end
         if (run_on) begin
            per   = m_h + m_l;
            maxph = 0;
            for (int i = 0; i < N_CH; i++) if (m_ph[i] > maxph) maxph = m_ph[i];
            n_rel = m_edge + 1 - m_t0;
            if (m_bl != 0 && n_rel == maxph + m_bl * per + 1) begin
               ev     = EW'(1);
               run_on = 0;
            end else begin
               for (int i = 0; i < N_CH; i++) begin
                  rel   = n_rel - 1 - m_ph[i];
                  ck[i] = (rel >= 0) && (m_bl == 0 || rel < m_bl * per) && ((rel % per) < m_h);
               end
               ev = {ck, 1'b1, 1'b0};
            end
         end
      end
      m_busy = ev[1];
      exp_q.push_back(ev);
      primed = 1;
      m_edge++;
   end

   task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s at %0t: got clk_out/busy/done=%b required %b", name, $time, got, want);
      end
   endtask

   // Monitor: one expected entry per cycle, compared mid-cycle.
   always @(negedge clk) begin
      logic [EW-1:0] w;
      if (exp_q.size() > 0) begin
         w = exp_q.pop_front();
         check("scoreboard", {clk_out, busy, done}, w);
      end else if (primed) begin
         n_vec++;
         n_err++;
         $display("FAIL scoreboard at %0t: got no expected entry required one per cycle", $time);
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers (inputs change 1 time unit after the falling edge).
   // ------------------------------------------------------------------------
   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic set_cfg(input int h, input int l, input int p0, input int p1, input int bl);
      high_time = CNT_W'(h);
      low_time  = CNT_W'(l);
      phase[0*CNT_W +: CNT_W] = CNT_W'(p0);
      phase[1*CNT_W +: CNT_W] = CNT_W'(p1);
      burst_len = BURST_W'(bl);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      bit seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         step(1);
         if (done) seen = 1;
      end
      if (!seen) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: got no done within %0d cycles required a done pulse", name, budget);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish by %0t required finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      stop = 1'b0;
      set_cfg(0, 0, 0, 0, 0);
      step(3);
      rst = 1'b0;
      step(1);
      check("reset_state", {clk_out, busy, done}, '0);

      // 1: H=5 L=5, ch1 phase 2, 10 periods
      set_cfg(5, 5, 0, 2, 10);
      pulse_start();
      wait_done("tp1_done", 150);
      check("tp1_done_cycle", {clk_out, busy, done}, EW'(1));
      step(2);

      // 2: zero times treated as one
      set_cfg(0, 0, 0, 0, 3);
      pulse_start();
      wait_done("tp2_done", 20);
      step(2);

      // 3: continuous, stopped
      set_cfg(3, 1, 0, 0, 0);
      pulse_start();
      step(48);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      check("tp3_after_stop", {clk_out, busy, done}, '0);
      step(3);

      // 4: second start with different H during the run is ignored
      set_cfg(4, 4, 0, 0, 2);
      pulse_start();
      step(1);
      high_time = 8'd7;
      pulse_start();
      wait_done("tp4_done", 40);
      step(2);

      // 5: restart in the done cycle
      set_cfg(2, 3, 0, 1, 2);
      pulse_start();
      wait_done("tp5_done", 40);
      set_cfg(3, 2, 0, 2, 1);
      pulse_start();
      check("tp5_restart", {clk_out, busy, done}, {2'b01, 1'b1, 1'b0});
      wait_done("tp5_done2", 40);
      step(2);

      // 6: asynchronous reset mid-HIGH at a non-edge time
      set_cfg(6, 6, 0, 3, 0);
      pulse_start();
      step(1);
      #1 rst = 1'b1;
      #1 check("tp6_async_rst", {clk_out, busy, done}, '0);
      step(2);
      rst = 1'b0;
      step(5);
      check("tp6_idle_after_rst", {clk_out, busy, done}, '0);

      // idle stop and start+stop together: no run
      stop = 1'b1;
      start = 1'b1;
      step(1);
      start = 1'b0;
      stop = 1'b0;
      step(1);
      check("start_stop_idle", {clk_out, busy, done}, '0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         start = ($urandom_range(0, 11) == 0);
         stop  = ($urandom_range(0, 59) == 0);
         if (start || $urandom_range(0, 3) == 0) begin
            set_cfg($urandom_range(0, 5), $urandom_range(0, 5),
                    $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 4));
         end
         step(1);
      end
      start = 1'b0;
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      step(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
